// File: rtl/data_memory_ctrl_if.sv
// -----------------------------------------------------------------------------
// data_memory_ctrl_if
// Request/response bus between the execute/memory stage (master) and the data
// memory controller (slave).
//   req_valid/req_ready      : request handshake, accept when both high
//   req_write/req_addr/...   : request payload, sampled only on accept
//   resp_valid/resp_ready    : response handshake, consume when both high
//   resp_rdata/resp_fault    : extended load data / fault flag of the response
//   busy_clear               : controller is zeroing the RAM after reset
// -----------------------------------------------------------------------------
interface data_memory_ctrl_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [2:0]  req_funct3;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_fault;
  logic        busy_clear;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, req_funct3, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_fault, busy_clear
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, req_funct3, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_fault, busy_clear
  );
endinterface

// File: rtl/data_memory_ctrl.sv
// -----------------------------------------------------------------------------
// data_memory_ctrl
// Word-organised, byte-enabled data RAM for the RV32I pipeline with a
// valid/ready request/response handshake, one-cycle registered read latency,
// RV32I load extension, fault reporting and an optional post-reset clear.
// Ports:
//   clk_in    : clock, all state updates on the rising edge
//   reset_in  : asynchronous active-high reset
//   s_bus     : data_memory_ctrl_if.slave (request, response, busy_clear)
// -----------------------------------------------------------------------------
module data_memory_ctrl #(
  parameter int unsigned MEMORY_SIZE    = 32'd1024,
  parameter bit          CLEAR_ON_RESET = 1'b1
) (
  input  logic              clk_in,
  input  logic              reset_in,
  data_memory_ctrl_if.slave s_bus
);

  localparam int unsigned INDEX_WIDTH = $clog2(MEMORY_SIZE);

  typedef enum logic [1:0] {
    ST_CLEAR = 2'd0,
    ST_IDLE  = 2'd1,
    ST_RESP  = 2'd2
  } state_t;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [INDEX_WIDTH-1:0] r_clr_cnt;
  logic [31:0]            r_resp_rdata;
  logic                   r_resp_fault;
  logic [31:0]            r_mem [MEMORY_SIZE];

  logic                   w_req_ready;
  logic                   w_accept;
  logic [INDEX_WIDTH-1:0] w_index;
  logic [1:0]             w_offset;
  logic                   w_out_of_range;
  logic                   w_misalign;
  logic                   w_illegal;
  logic                   w_fault;
  logic [3:0]             w_be;
  logic [31:0]            w_st_data;
  logic                   w_st_we;
  logic                   w_clr_we;

  // Select the addressed byte/half of a word and extend it as funct3 requests.
  function automatic logic [31:0] f_load_ext(input logic [31:0] i_word,
                                             input logic [1:0]  i_off,
                                             input logic [2:0]  i_f3);
    logic [7:0]  v_byte;
    logic [15:0] v_half;
    v_byte = i_word[{i_off, 3'b000} +: 8];
    v_half = i_off[1] ? i_word[31:16] : i_word[15:0];
    case (i_f3)
      3'd0:    f_load_ext = {{24{v_byte[7]}}, v_byte};
      3'd1:    f_load_ext = {{16{v_half[15]}}, v_half};
      3'd2:    f_load_ext = i_word;
      3'd4:    f_load_ext = {24'd0, v_byte};
      3'd5:    f_load_ext = {16'd0, v_half};
      default: f_load_ext = 32'd0;
    endcase
  endfunction

  assign w_index  = s_bus.req_addr[INDEX_WIDTH+1:2];
  assign w_offset = s_bus.req_addr[1:0];
  assign w_accept = s_bus.req_valid & w_req_ready;

  // Fault classification of the presented request (used only on accept).
  always_comb begin
    w_out_of_range = (s_bus.req_addr >> (INDEX_WIDTH + 2)) != 32'd0;
    w_misalign     = 1'b0;
    w_illegal      = 1'b0;
    case (s_bus.req_funct3)
      3'd0: w_illegal = 1'b0;
      3'd1: w_misalign = s_bus.req_addr[0];
      3'd2: w_misalign = (s_bus.req_addr[1:0] != 2'b00);
      3'd4: w_illegal = s_bus.req_write;   // LBU has no store counterpart
      3'd5: begin
        w_misalign = s_bus.req_addr[0];
        w_illegal  = s_bus.req_write;      // LHU has no store counterpart
      end
      default: w_illegal = 1'b1;           // funct3 3, 6, 7
    endcase
    w_fault = w_out_of_range | w_misalign | w_illegal;
  end

  // Store byte lanes and lane-replicated write data.
  always_comb begin
    w_be      = 4'b0000;
    w_st_data = 32'd0;
    case (s_bus.req_funct3)
      3'd0: begin
        w_be      = 4'b0001 << w_offset;
        w_st_data = {4{s_bus.req_wdata[7:0]}};
      end
      3'd1: begin
        w_be      = w_offset[1] ? 4'b1100 : 4'b0011;
        w_st_data = {2{s_bus.req_wdata[15:0]}};
      end
      3'd2: begin
        w_be      = 4'b1111;
        w_st_data = s_bus.req_wdata;
      end
      default: begin
        w_be      = 4'b0000;
        w_st_data = 32'd0;
      end
    endcase
  end

  // Write enables are gated with reset_in so no RAM write happens during reset.
  assign w_st_we  = w_accept & s_bus.req_write & ~w_fault & ~reset_in;
  assign w_clr_we = (r_state == ST_CLEAR) & ~reset_in;

  // RAM write port: clear sequence or an accepted non-faulting store.
  always_ff @(posedge clk_in) begin
    if (w_clr_we) begin
      r_mem[r_clr_cnt] <= 32'd0;
    end else if (w_st_we) begin
      for (int b = 0; b < 4; b++) begin
        if (w_be[b]) begin
          r_mem[w_index][8*b +: 8] <= w_st_data[8*b +: 8];
        end
      end
    end
  end

  // State and clear-counter registers.
  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      r_state   <= CLEAR_ON_RESET ? ST_CLEAR : ST_IDLE;
      r_clr_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == ST_CLEAR) begin
        r_clr_cnt <= r_clr_cnt + INDEX_WIDTH'(1);
      end
    end
  end

  // Next-state and handshake outputs; ready in RESP follows resp_ready so a
  // consumed response can be replaced in the same cycle.
  always_comb begin
    w_state_nxt = r_state;
    w_req_ready = 1'b0;
    case (r_state)
      ST_CLEAR: begin
        w_req_ready = 1'b0;
        if (r_clr_cnt == INDEX_WIDTH'(MEMORY_SIZE - 1)) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_CLEAR;
        end
      end
      ST_IDLE: begin
        w_req_ready = 1'b1;
        if (s_bus.req_valid) begin
          w_state_nxt = ST_RESP;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_RESP: begin
        w_req_ready = s_bus.resp_ready;
        if (s_bus.resp_ready && !s_bus.req_valid) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_RESP;
        end
      end
      default: begin
        w_req_ready = 1'b0;
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Response registers: the RAM word is read on the accept edge, so a store
  // accepted on the previous edge is already visible.
  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      r_resp_rdata <= 32'd0;
      r_resp_fault <= 1'b0;
    end else if (w_accept) begin
      r_resp_fault <= w_fault;
      if (w_fault || s_bus.req_write) begin
        r_resp_rdata <= 32'd0;
      end else begin
        r_resp_rdata <= f_load_ext(r_mem[w_index], w_offset, s_bus.req_funct3);
      end
    end
  end

  assign s_bus.req_ready  = w_req_ready;
  assign s_bus.resp_valid = (r_state == ST_RESP);
  assign s_bus.resp_rdata = r_resp_rdata;
  assign s_bus.resp_fault = r_resp_fault;
  assign s_bus.busy_clear = (r_state == ST_CLEAR);

endmodule

// File: tb/tb_data_memory_ctrl.sv
// -----------------------------------------------------------------------------
// tb_data_memory_ctrl
// Directed bench for data_memory_ctrl (MEMORY_SIZE=1024, CLEAR_ON_RESET=1):
// clear sequence, stores/loads with extension, faults, backpressure,
// streaming and reset during CLEAR/RESP. Expected values are hand computed.
// -----------------------------------------------------------------------------
module tb_data_memory_ctrl;

  localparam int MEM_WORDS = 1024;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;

  data_memory_ctrl_if bus ();

  data_memory_ctrl #(
    .MEMORY_SIZE   (MEM_WORDS),
    .CLEAR_ON_RESET(1'b1)
  ) u_dut (
    .clk_in  (clk),
    .reset_in(rst),
    .s_bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1, "watchdog");
  end

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  // One request; waits (bounded) for acceptance and checks the response.
  task automatic xact(input string tag, input logic wr, input logic [31:0] a,
                      input logic [31:0] d, input logic [2:0] f3,
                      input logic [31:0] exp_d, input logic exp_f);
    int n;
    n = 0;
    @(negedge clk);
    bus.req_valid  = 1'b1;
    bus.req_write  = wr;
    bus.req_addr   = a;
    bus.req_wdata  = d;
    bus.req_funct3 = f3;
    while (!bus.req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check_val({tag, "_accept"}, 32'(n < 50), 32'd1);
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    check_val({tag, "_valid"}, 32'(bus.resp_valid), 32'd1);
    check_val({tag, "_data"}, bus.resp_rdata, exp_d);
    check_val({tag, "_fault"}, 32'(bus.resp_fault), 32'(exp_f));
  endtask

  // Counts cycles with busy_clear high (bounded) and cycles where ready was seen.
  task automatic clear_wait(output int cyc, output int rdy_hi);
    cyc    = 0;
    rdy_hi = 0;
    while (bus.busy_clear && cyc < 4000) begin
      if (bus.req_ready) rdy_hi++;
      @(posedge clk);
      #1;
      cyc++;
    end
  endtask

  logic [31:0] s_addr [4];
  logic [2:0]  s_f3   [4];
  logic [31:0] s_exp  [4];

  initial begin
    int cyc;
    int rdy;
    n_tests = 0;
    n_fail  = 0;
    s_addr = '{32'h10, 32'h20, 32'h3C, 32'h13};
    s_f3   = '{3'd2, 3'd2, 3'd2, 3'd4};
    s_exp  = '{32'h8899AABB, 32'h5566EE44, 32'h00000000, 32'h00000088};

    bus.req_valid  = 1'b0;
    bus.req_write  = 1'b0;
    bus.req_addr   = 32'd0;
    bus.req_wdata  = 32'd0;
    bus.req_funct3 = 3'd0;
    bus.resp_ready = 1'b1;
    rst = 1'b1;
    #1;
    check_val("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
    check_val("rst_rdata", bus.resp_rdata, 32'd0);
    check_val("rst_fault", 32'(bus.resp_fault), 32'd0);
    check_val("rst_busy", 32'(bus.busy_clear), 32'd1);
    check_val("rst_ready", 32'(bus.req_ready), 32'd0);

    @(negedge clk);
    rst = 1'b0;
    clear_wait(cyc, rdy);
    check_val("clear_cycles", 32'(cyc), 32'(MEM_WORDS));
    check_val("clear_ready_seen", 32'(rdy), 32'd0);

    xact("lw_3c", 1'b0, 32'h3C, 32'd0, 3'd2, 32'h00000000, 1'b0);
    xact("lw_last", 1'b0, 32'hFFC, 32'd0, 3'd2, 32'h00000000, 1'b0);
    xact("sw_last", 1'b1, 32'hFFC, 32'hCAFEF00D, 3'd2, 32'h00000000, 1'b0);
    xact("lw_last2", 1'b0, 32'hFFC, 32'd0, 3'd2, 32'hCAFEF00D, 1'b0);

    // Extension of loads; first load directly follows the store.
    xact("sw_10", 1'b1, 32'h10, 32'h8899AABB, 3'd2, 32'h00000000, 1'b0);
    xact("lb_13", 1'b0, 32'h13, 32'd0, 3'd0, 32'hFFFFFF88, 1'b0);
    xact("lbu_13", 1'b0, 32'h13, 32'd0, 3'd4, 32'h00000088, 1'b0);
    xact("lh_10", 1'b0, 32'h10, 32'd0, 3'd1, 32'hFFFFAABB, 1'b0);
    xact("lhu_12", 1'b0, 32'h12, 32'd0, 3'd5, 32'h00008899, 1'b0);
    xact("lh_12", 1'b0, 32'h12, 32'd0, 3'd1, 32'hFFFF8899, 1'b0);
    xact("lb_10", 1'b0, 32'h10, 32'd0, 3'd0, 32'hFFFFFFBB, 1'b0);
    xact("lbu_11", 1'b0, 32'h11, 32'd0, 3'd4, 32'h000000AA, 1'b0);
    xact("lhu_10", 1'b0, 32'h10, 32'd0, 3'd5, 32'h0000AABB, 1'b0);

    // Partial stores into one word.
    xact("sw_20", 1'b1, 32'h20, 32'h11223344, 3'd2, 32'h00000000, 1'b0);
    xact("sb_21", 1'b1, 32'h21, 32'h000000EE, 3'd0, 32'h00000000, 1'b0);
    xact("sh_22", 1'b1, 32'h22, 32'h00005566, 3'd1, 32'h00000000, 1'b0);
    xact("lw_20", 1'b0, 32'h20, 32'd0, 3'd2, 32'h5566EE44, 1'b0);

    // Faults: memory must stay unchanged.
    xact("f_lw_02", 1'b0, 32'h02, 32'd0, 3'd2, 32'h00000000, 1'b1);
    xact("f_sh_01", 1'b1, 32'h01, 32'h0000FFFF, 3'd1, 32'h00000000, 1'b1);
    xact("f_lb_oor", 1'b0, 32'h00001000, 32'd0, 3'd0, 32'h00000000, 1'b1);
    xact("f_sw_oor", 1'b1, 32'h00001000, 32'h12345678, 3'd2, 32'h00000000, 1'b1);
    xact("f_st_f3", 1'b1, 32'h20, 32'hDEADBEEF, 3'd3, 32'h00000000, 1'b1);
    xact("f_ld_f3_6", 1'b0, 32'h20, 32'd0, 3'd6, 32'h00000000, 1'b1);
    xact("f_sbu", 1'b1, 32'h20, 32'hDEADBEEF, 3'd4, 32'h00000000, 1'b1);
    xact("chk_w0", 1'b0, 32'h00, 32'd0, 3'd2, 32'h00000000, 1'b0);
    xact("chk_w20", 1'b0, 32'h20, 32'd0, 3'd2, 32'h5566EE44, 1'b0);

    // Backpressure: response held, no accept while resp_ready=0.
    repeat (2) @(negedge clk);
    bus.resp_ready = 1'b0;
    xact("bp_lw", 1'b0, 32'h10, 32'd0, 3'd2, 32'h8899AABB, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      bus.req_valid  = 1'b1;
      bus.req_write  = 1'b1;
      bus.req_funct3 = 3'd2;
      bus.req_wdata  = 32'hBAD0BAD0;
      bus.req_addr   = 32'h20 + 32'(i * 4);
      #1;
      check_val("bp_ready", 32'(bus.req_ready), 32'd0);
      check_val("bp_valid", 32'(bus.resp_valid), 32'd1);
      check_val("bp_data", bus.resp_rdata, 32'h8899AABB);
    end

    // Streaming: one response per cycle, in order.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      bus.req_valid  = 1'b1;
      bus.req_write  = 1'b0;
      bus.req_addr   = s_addr[i];
      bus.req_funct3 = s_f3[i];
      bus.resp_ready = 1'b1;
      #1;
      check_val("st_ready", 32'(bus.req_ready), 32'd1);
      @(posedge clk);
      #1;
      check_val("st_valid", 32'(bus.resp_valid), 32'd1);
      check_val("st_data", bus.resp_rdata, s_exp[i]);
    end
    bus.req_valid = 1'b0;
    xact("bp_no_write", 1'b0, 32'h20, 32'd0, 3'd2, 32'h5566EE44, 1'b0);

    // Reset while a response is pending drops it asynchronously.
    @(negedge clk);
    bus.resp_ready = 1'b0;
    #1;
    check_val("rr_pre_valid", 32'(bus.resp_valid), 32'd1);
    #1;
    rst = 1'b1;
    #1;
    check_val("rr_valid", 32'(bus.resp_valid), 32'd0);
    check_val("rr_rdata", bus.resp_rdata, 32'd0);
    check_val("rr_busy", 32'(bus.busy_clear), 32'd1);
    bus.resp_ready = 1'b1;
    @(negedge clk);
    rst = 1'b0;

    // Reset in the middle of the clear restarts it from word 0.
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_val("rc_busy", 32'(bus.busy_clear), 32'd1);
    check_val("rc_ready", 32'(bus.req_ready), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    clear_wait(cyc, rdy);
    check_val("rc_cycles", 32'(cyc), 32'(MEM_WORDS));
    check_val("rc_ready_seen", 32'(rdy), 32'd0);
    xact("rc_lw_10", 1'b0, 32'h10, 32'd0, 3'd2, 32'h00000000, 1'b0);
    xact("rc_lw_last", 1'b0, 32'hFFC, 32'd0, 3'd2, 32'h00000000, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/data_memory_ctrl.md
Name: data_memory_ctrl

Overview:
- Parametrised successor to the single-cycle data RAM for the RV32I core.
- Word-organised byte-enabled RAM with a valid/ready request/response handshake and one-cycle registered read latency.
- Adds RV32I load extension (LB/LH/LW/LBU/LHU), misalignment/range/illegal-funct3 fault reporting, and an optional post-reset clear sequence.
- Sits between the execute/memory stage and the pipeline's writeback mux.

Parameters:
- MEMORY_SIZE, 1024: number of 32-bit words; must be a power of two, 2..65536. INDEX_WIDTH = clog2(MEMORY_SIZE) is a localparam.
- CLEAR_ON_RESET, 1: 1 = zero all words after reset before accepting requests; 0 = RAM contents undefined, ready immediately.

Ports:
- clk_in  input  1  clock, all state updates on rising edge
- reset_in  input  1  asynchronous, active-high reset
- req_valid  input  1  request present
- req_ready  output  1  request accepted this cycle when req_valid && req_ready
- req_write  input  1  1 = store, 0 = load
- req_addr  input  32  byte address
- req_wdata  input  32  store data (low byte/half used for SB/SH)
- req_funct3  input  3  RV32I funct3; load 0=LB 1=LH 2=LW 4=LBU 5=LHU; store 0=SB 1=SH 2=SW
- resp_valid  output  1  response present
- resp_ready  input  1  consumer takes response when resp_valid && resp_ready
- resp_rdata  output  32  extended load data; 0 for stores and faults
- resp_fault  output  1  request faulted; memory unchanged
- busy_clear  output  1  high while the clear sequence runs

Behaviour:
- Reset (async, takes effect immediately): resp_valid=0, resp_rdata=0, resp_fault=0, clear counter=0, state=CLEAR if CLEAR_ON_RESET else IDLE; busy_clear=1 iff state is CLEAR.
- RAM contents are never reset directly. No RAM write occurs on any edge while reset_in=1.
- States:
  - CLEAR: writes 0 to word[counter], counter++ each cycle; req_ready=0. After word MEMORY_SIZE-1 is written, go to IDLE. The sequence takes exactly MEMORY_SIZE cycles.
  - IDLE: req_ready=1. On accept, go to RESP.
  - RESP: resp_valid=1. req_ready=resp_ready, so back-to-back throughput is 1 request/cycle.
    - resp_ready=1 with a new accept: stay in RESP with the new response.
    - resp_ready=1 without an accept: go to IDLE.
    - resp_ready=0: hold resp_rdata/resp_fault stable, no accept.
- Index = req_addr[INDEX_WIDTH+1:2]; byte offset = req_addr[1:0].
- Fault conditions, evaluated at accept:
  - req_addr[31:INDEX_WIDTH+2] != 0 (out of range);
  - halfword access with addr[0]=1;
  - word access with addr[1:0]!=0;
  - load funct3 in {3,6,7};
  - store funct3 in {3..7}.
- Faulted request: no RAM write; response has resp_fault=1, resp_rdata=0.
- Store, write on the accept edge:
  - SB: byte lane = offset, data replicated {4{wdata[7:0]}}.
  - SH: lanes 1:0 if offset[1]=0, else 3:2, data {2{wdata[15:0]}}.
  - SW: all lanes.
  - Store response: resp_rdata=0, resp_fault=0.
- Load, RAM read on the accept edge, extended data registered into resp_rdata (latency 1 cycle from accept):
  - Select byte (offset) or half (offset[1]).
  - LB/LH: sign-extend. LBU/LHU: zero-extend. LW: full word.
- Read-during-write: a load accepted the cycle after a store to the same word returns the new data. Only one request is accepted per edge, so a same-edge conflict cannot occur.
- Reset during CLEAR restarts the clear from word 0. Reset during RESP drops the pending response.
- req_* inputs are sampled only on accept. Changes to req_* while req_ready=0 have no effect.

Test Plan:
- CLEAR_ON_RESET=1, MEMORY_SIZE=16, deassert reset:
  - busy_clear=1 and req_ready=0 for exactly 16 cycles;
  - then LW 0x3C -> resp_rdata=0x00000000, fault=0.
- SW 0x10 data 0x8899AABB, then in sequence:
  - LB 0x13 -> 0xFFFFFF88;
  - LBU 0x13 -> 0x00000088;
  - LH 0x10 -> 0xFFFFAABB;
  - LHU 0x12 -> 0x00008899.
- After SW 0x20=0x11223344:
  - SB 0x21 wdata 0x000000EE, then SH 0x22 wdata 0x00005566;
  - LW 0x20 -> 0x5566EE44.
- Faults: LW 0x02, SH 0x01, LB at 0x00001000 (MEMORY_SIZE=1024), store funct3=3.
  - Each returns resp_fault=1, rdata=0.
  - Follow-up LW to the covered words shows no change.
- Backpressure: hold resp_ready=0 for 3 cycles after LW 0x10:
  - req_ready=0 and resp_rdata stays 0x8899AABB.
  - Then resp_ready=1 with 4 streamed loads -> one response per cycle, in order.
- Assert reset_in mid-CLEAR (cycle 5) and while resp_valid=1:
  - resp_valid drops to 0 immediately (asynchronously, before the next clock edge);
  - clear restarts and busy_clear spans a full MEMORY_SIZE cycles.
